// File: rtl/pc_run_ctrl.sv
// pc_run_ctrl: run-control sequencer for the emulator program counter.
// It parks the PC in IDLE, loads the entry point in LOAD, and retires one
// instruction per cycle in RUN, holding the PC on a stall. A decoded halt
// or the instruction-count watchdog ends the run in DONE.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   go, start_addr         run request and entry point (sampled in IDLE/DONE)
//   pc_in                  current PC fed back from the program counter
//   halt, stall            decoder halt and pipeline hold requests
//   br_in, taken_in        decoder branch / branch-taken flags
//   pc_start*, pc_branch,  PC control (combinational from state and inputs)
//   pc_taken
//   busy, done             decoded from the state register
//   timeout, instr_count   registered watchdog flag and retired count
module pc_run_ctrl #(
  parameter int unsigned ROM_SIZE  = 512,
  parameter int unsigned MAX_INSTR = 4096,
  parameter int unsigned CNT_W     = 16,
  localparam int unsigned AW       = $clog2(ROM_SIZE) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic [AW-1:0]    start_addr,
  input  logic [AW-1:0]    pc_in,
  input  logic             halt,
  input  logic             stall,
  input  logic             br_in,
  input  logic             taken_in,
  output logic             pc_start,
  output logic [AW-1:0]    pc_start_addr,
  output logic             pc_branch,
  output logic             pc_taken,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_INSTR - 1);

  state_e           state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             timeout_q, timeout_d;

  // State and run bookkeeping registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      count_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      count_q   <= count_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic and PC control; PC is reloaded (held) unless retiring
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    count_d       = count_q;
    timeout_d     = timeout_q;
    pc_start      = 1'b1;
    pc_start_addr = addr_q;
    pc_branch     = 1'b0;
    pc_taken      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (go) begin
          addr_d    = start_addr;
          count_d   = '0;
          timeout_d = 1'b0;
          state_d   = ST_LOAD;
        end
      end

      ST_LOAD: begin
        state_d = ST_RUN;
      end

      ST_RUN: begin
        pc_start_addr = pc_in;
        if (halt) begin
          state_d = ST_DONE;
        end else if (!stall) begin
          // Retire: hand the PC over to sequential/branch advance
          pc_start  = 1'b0;
          pc_branch = br_in;
          pc_taken  = br_in & taken_in;
          count_d   = count_q + CNT_W'(1);
          if (count_q == LAST_CNT) begin
            timeout_d = 1'b1;
            state_d   = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        pc_start_addr = pc_in;
        if (go) begin
          addr_d    = start_addr;
          count_d   = '0;
          timeout_d = 1'b0;
          state_d   = ST_LOAD;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy        = (state_q == ST_LOAD) || (state_q == ST_RUN);
  assign done        = (state_q == ST_DONE);
  assign timeout     = timeout_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_pc_run_ctrl.sv
// Directed bench for pc_run_ctrl. Two instances: the default watchdog
// (4096) for the main program flow and MAX_INSTR=8 for the watchdog case.
// Each instance drives a small behavioural program counter in the bench.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_pc_run_ctrl;

  localparam int unsigned AW    = 10;
  localparam int unsigned CNT_W = 16;

  logic clk;
  logic rst_n;
  logic go, go8;
  logic [AW-1:0] start_addr;
  logic halt, stall, br_in, taken_in;
  logic [AW-1:0] br_off;

  logic [AW-1:0]    pc, pc8;
  logic             pc_start, pc_branch, pc_taken, busy, done, timeout;
  logic [AW-1:0]    pc_start_addr;
  logic [CNT_W-1:0] instr_count;
  logic             pc_start8, pc_branch8, pc_taken8, busy8, done8, timeout8;
  logic [AW-1:0]    pc_start_addr8;
  logic [CNT_W-1:0] instr_count8;

  int vec_cnt;
  int err_cnt;

  pc_run_ctrl dut (
    .clk(clk), .rst_n(rst_n), .go(go), .start_addr(start_addr), .pc_in(pc),
    .halt(halt), .stall(stall), .br_in(br_in), .taken_in(taken_in),
    .pc_start(pc_start), .pc_start_addr(pc_start_addr), .pc_branch(pc_branch),
    .pc_taken(pc_taken), .busy(busy), .done(done), .timeout(timeout),
    .instr_count(instr_count)
  );

  pc_run_ctrl #(.MAX_INSTR(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .go(go8), .start_addr(start_addr), .pc_in(pc8),
    .halt(halt), .stall(stall), .br_in(br_in), .taken_in(taken_in),
    .pc_start(pc_start8), .pc_start_addr(pc_start_addr8), .pc_branch(pc_branch8),
    .pc_taken(pc_taken8), .busy(busy8), .done(done8), .timeout(timeout8),
    .instr_count(instr_count8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural program counter: load, +1, +2 (not taken) or +offset (taken)
  always @(posedge clk) begin
    if (pc_start)                   pc <= pc_start_addr;
    else if (pc_branch && pc_taken) pc <= pc + br_off;
    else if (pc_branch)             pc <= pc + 10'd2;
    else                            pc <= pc + 10'd1;
    if (pc_start8)                    pc8 <= pc_start_addr8;
    else if (pc_branch8 && pc_taken8) pc8 <= pc8 + br_off;
    else if (pc_branch8)              pc8 <= pc8 + 10'd2;
    else                              pc8 <= pc8 + 10'd1;
  end

  task automatic cyc;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) cyc();
    #1;
    vec_cnt++; if (pc_start !== 1'b1) begin err_cnt++; $display("FAIL rst_pc_start got %b want 1", pc_start); end
    vec_cnt++; if (pc_start_addr !== 10'h000) begin err_cnt++; $display("FAIL rst_pc_start_addr got %h want 000", pc_start_addr); end
    vec_cnt++; if ({pc_branch, pc_taken, busy, done} !== 4'b0000) begin err_cnt++; $display("FAIL rst_flags got %b want 0000", {pc_branch, pc_taken, busy, done}); end
    vec_cnt++; if (instr_count !== 16'd0 || timeout !== 1'b0) begin err_cnt++; $display("FAIL rst_count got %0d/%b want 0/0", instr_count, timeout); end
    cyc();
    rst_n = 1'b1;
    cyc();
    #1;
    vec_cnt++; if (pc !== 10'h000) begin err_cnt++; $display("FAIL rst_pc_load got %h want 000", pc); end
  endtask

  // go at 0x010, then five straight-line retires
  task automatic test_linear;
    logic [AW-1:0] exp_pc;
    start_addr = 10'h010;
    go = 1'b1;
    cyc();
    go = 1'b0;
    #1;
    vec_cnt++; if (busy !== 1'b1 || pc_start !== 1'b1 || pc_start_addr !== 10'h010) begin err_cnt++; $display("FAIL load_outs got busy=%b start=%b addr=%h want 1 1 010", busy, pc_start, pc_start_addr); end
    vec_cnt++; if (instr_count !== 16'd0) begin err_cnt++; $display("FAIL load_count got %0d want 0", instr_count); end
    cyc();
    for (int i = 0; i < 5; i++) begin
      exp_pc = 10'h010 + 10'(i);
      #1;
      vec_cnt++; if (pc !== exp_pc) begin err_cnt++; $display("FAIL lin_pc[%0d] got %h want %h", i, pc, exp_pc); end
      vec_cnt++; if (instr_count !== 16'(i) || busy !== 1'b1 || pc_start !== 1'b0) begin err_cnt++; $display("FAIL lin_state[%0d] got cnt=%0d busy=%b start=%b want %0d 1 0", i, instr_count, busy, pc_start, i); end
      cyc();
    end
  endtask

  // Three stall cycles at 0x015, then resume there
  task automatic test_stall;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      vec_cnt++; if (pc_start !== 1'b1 || pc_start_addr !== 10'h015) begin err_cnt++; $display("FAIL stall_out[%0d] got start=%b addr=%h want 1 015", i, pc_start, pc_start_addr); end
      vec_cnt++; if (pc !== 10'h015 || instr_count !== 16'd5) begin err_cnt++; $display("FAIL stall_hold[%0d] got pc=%h cnt=%0d want 015 5", i, pc, instr_count); end
      cyc();
    end
    stall = 1'b0;
    #1;
    vec_cnt++; if (pc !== 10'h015 || pc_start !== 1'b0 || instr_count !== 16'd5) begin err_cnt++; $display("FAIL stall_resume got pc=%h start=%b cnt=%0d want 015 0 5", pc, pc_start, instr_count); end
    cyc();
  endtask

  // Not-taken (+2), taken (-3), taken without branch (ignored), taken (+4)
  task automatic test_branch;
    logic [AW-1:0] exp_pc;
    br_in = 1'b1; taken_in = 1'b0;
    #1;
    vec_cnt++; if (pc_branch !== 1'b1 || pc_taken !== 1'b0 || pc !== 10'h016) begin err_cnt++; $display("FAIL br_nt got br=%b tk=%b pc=%h want 1 0 016", pc_branch, pc_taken, pc); end
    cyc();
    taken_in = 1'b1; br_off = 10'h3FD;
    #1;
    vec_cnt++; if (pc_taken !== 1'b1 || pc !== 10'h018 || instr_count !== 16'd7) begin err_cnt++; $display("FAIL br_tk got tk=%b pc=%h cnt=%0d want 1 018 7", pc_taken, pc, instr_count); end
    cyc();
    br_in = 1'b0;
    #1;
    vec_cnt++; if (pc_branch !== 1'b0 || pc_taken !== 1'b0 || pc !== 10'h015 || instr_count !== 16'd8) begin err_cnt++; $display("FAIL br_tk_only got br=%b tk=%b pc=%h cnt=%0d want 0 0 015 8", pc_branch, pc_taken, pc, instr_count); end
    cyc();
    br_in = 1'b1; br_off = 10'd4;
    #1;
    vec_cnt++; if (pc !== 10'h016 || instr_count !== 16'd9) begin err_cnt++; $display("FAIL br_fwd got pc=%h cnt=%0d want 016 9", pc, instr_count); end
    cyc();
    br_in = 1'b0; taken_in = 1'b0;
    for (int i = 0; i < 6; i++) begin
      exp_pc = 10'h01A + 10'(i);
      #1;
      vec_cnt++; if (pc !== exp_pc || instr_count !== 16'(10 + i)) begin err_cnt++; $display("FAIL br_after[%0d] got pc=%h cnt=%0d want %h %0d", i, pc, instr_count, exp_pc, 10 + i); end
      cyc();
    end
  endtask

  // halt+stall at 0x020 with 16 retired, then restart from 0x040
  task automatic test_halt_restart;
    halt = 1'b1; stall = 1'b1;
    #1;
    vec_cnt++; if (pc !== 10'h020 || instr_count !== 16'd16 || pc_start !== 1'b1 || pc_start_addr !== 10'h020) begin err_cnt++; $display("FAIL halt_cyc got pc=%h cnt=%0d start=%b addr=%h want 020 16 1 020", pc, instr_count, pc_start, pc_start_addr); end
    cyc();
    halt = 1'b0; stall = 1'b0;
    #1;
    vec_cnt++; if (done !== 1'b1 || busy !== 1'b0 || timeout !== 1'b0) begin err_cnt++; $display("FAIL halt_done got done=%b busy=%b to=%b want 1 0 0", done, busy, timeout); end
    vec_cnt++; if (pc !== 10'h020 || instr_count !== 16'd16) begin err_cnt++; $display("FAIL halt_hold got pc=%h cnt=%0d want 020 16", pc, instr_count); end
    cyc();
    #1;
    vec_cnt++; if (pc !== 10'h020 || done !== 1'b1 || pc_start_addr !== 10'h020) begin err_cnt++; $display("FAIL done_frozen got pc=%h done=%b addr=%h want 020 1 020", pc, done, pc_start_addr); end
    start_addr = 10'h040; go = 1'b1;
    cyc();
    go = 1'b0;
    #1;
    vec_cnt++; if (instr_count !== 16'd0 || busy !== 1'b1 || done !== 1'b0 || pc_start_addr !== 10'h040) begin err_cnt++; $display("FAIL restart_load got cnt=%0d busy=%b done=%b addr=%h want 0 1 0 040", instr_count, busy, done, pc_start_addr); end
    cyc();
    halt = 1'b1;
    #1;
    vec_cnt++; if (pc !== 10'h040) begin err_cnt++; $display("FAIL restart_pc got %h want 040", pc); end
    cyc();
    halt = 1'b0;
    #1;
    vec_cnt++; if (done !== 1'b1 || instr_count !== 16'd0) begin err_cnt++; $display("FAIL halt_first got done=%b cnt=%0d want 1 0", done, instr_count); end
  endtask

  // MAX_INSTR=8 instance: watchdog ends the run, go during RUN ignored
  task automatic test_watchdog;
    start_addr = 10'h100; go8 = 1'b1;
    cyc();
    go8 = 1'b0;
    cyc();
    for (int i = 0; i < 8; i++) begin
      go8 = (i == 3);
      #1;
      vec_cnt++; if (busy8 !== 1'b1 || timeout8 !== 1'b0 || instr_count8 !== 16'(i) || pc8 !== 10'h100 + 10'(i)) begin err_cnt++; $display("FAIL wd_run[%0d] got busy=%b to=%b cnt=%0d pc=%h want 1 0 %0d %h", i, busy8, timeout8, instr_count8, pc8, i, 10'h100 + 10'(i)); end
      cyc();
    end
    go8 = 1'b0;
    #1;
    vec_cnt++; if (done8 !== 1'b1 || timeout8 !== 1'b1 || busy8 !== 1'b0) begin err_cnt++; $display("FAIL wd_done got done=%b to=%b busy=%b want 1 1 0", done8, timeout8, busy8); end
    vec_cnt++; if (instr_count8 !== 16'd8 || pc8 !== 10'h108) begin err_cnt++; $display("FAIL wd_count got cnt=%0d pc=%h want 8 108", instr_count8, pc8); end
    cyc();
    #1;
    vec_cnt++; if (pc8 !== 10'h108 || instr_count8 !== 16'd8 || timeout8 !== 1'b1) begin err_cnt++; $display("FAIL wd_hold got pc=%h cnt=%0d to=%b want 108 8 1", pc8, instr_count8, timeout8); end
  endtask

  // Async reset mid-RUN at count 5
  task automatic test_reset_midrun;
    cyc();
    start_addr = 10'h030; go = 1'b1;
    cyc();
    go = 1'b0;
    cyc();
    repeat (5) cyc();
    #1;
    vec_cnt++; if (instr_count !== 16'd5 || pc !== 10'h035) begin err_cnt++; $display("FAIL mid_pre got cnt=%0d pc=%h want 5 035", instr_count, pc); end
    br_in = 1'b1; taken_in = 1'b1;
    rst_n = 1'b0;
    #1;
    vec_cnt++; if (pc_start !== 1'b1 || pc_start_addr !== 10'h000 || pc_branch !== 1'b0 || pc_taken !== 1'b0) begin err_cnt++; $display("FAIL mid_rst_pc got start=%b addr=%h br=%b tk=%b want 1 000 0 0", pc_start, pc_start_addr, pc_branch, pc_taken); end
    vec_cnt++; if (busy !== 1'b0 || done !== 1'b0 || instr_count !== 16'd0 || timeout !== 1'b0) begin err_cnt++; $display("FAIL mid_rst_st got busy=%b done=%b cnt=%0d to=%b want 0 0 0 0", busy, done, instr_count, timeout); end
    cyc();
    #1;
    vec_cnt++; if (pc !== 10'h000) begin err_cnt++; $display("FAIL mid_rst_pc_load got %h want 000", pc); end
    br_in = 1'b0; taken_in = 1'b0;
    rst_n = 1'b1;
    cyc();
  endtask

  initial begin
    vec_cnt = 0; err_cnt = 0;
    rst_n = 1'b0; go = 1'b0; go8 = 1'b0; start_addr = '0;
    halt = 1'b0; stall = 1'b0; br_in = 1'b0; taken_in = 1'b0;
    br_off = '0;
    pc = 10'h3FF; pc8 = 10'h3FF;
    test_reset();
    test_linear();
    test_stall();
    test_branch();
    test_halt_restart();
    test_watchdog();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/pc_run_ctrl.md
# pc_run_ctrl

Run-control sequencer for the emulator core's program counter. It owns the counter's `start`/`start_addr`/`branch`/`taken` inputs and moves a program through idle, load, run and done phases. It inserts stalls by reloading the current PC, stops on a decoded halt or an instruction-count watchdog, and reports completion and retired-instruction count to the top-level test harness. It sits between the instruction decoder (branch, taken and halt decode) and the program counter.

## Interface
Parameters:
- `ROM_SIZE`, 512: instruction ROM depth. `AW = $clog2(ROM_SIZE)+1` is the PC width (10 bits at default).
- `MAX_INSTR`, 4096: watchdog limit on retired instructions. Must be ≥1.
- `CNT_W`, 16: width of `instr_count`. Must satisfy `2^CNT_W > MAX_INSTR`.

Ports (reset is asynchronous, active-low, named `rst_n`; single clock `clk`):
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous active-low reset.
- `go` in 1: run request. Sampled only in IDLE and DONE.
- `start_addr` in AW: program entry point. Captured when `go` is accepted.
- `pc_in` in AW: current PC value, fed back from the program counter.
- `halt` in 1: decoder says the instruction at `pc_in` is HALT.
- `stall` in 1: hold the PC this cycle.
- `br_in` in 1: decoder branch flag.
- `taken_in` in 1: decoder branch-taken flag.
- `pc_start` out 1: drives the PC `start` input.
- `pc_start_addr` out AW: drives the PC `start_addr` input.
- `pc_branch` out 1: drives the PC `branch` input.
- `pc_taken` out 1: drives the PC `taken` input.
- `busy` out 1: high in LOAD and RUN.
- `done` out 1: high in DONE.
- `timeout` out 1: sticky flag, set when the watchdog ended the run.
- `instr_count` out CNT_W: instructions retired in the current or last run.

## Operation
- State register: IDLE, LOAD, RUN, DONE. Registered state: `addr_q` (AW), `instr_count`, `timeout`.
- PC control outputs are combinational from state and inputs.
- IDLE:
  - Drives `pc_start`=1, `pc_start_addr`=`addr_q`, so the PC is parked at `addr_q`.
  - On `go`: `addr_q` ← `start_addr`, `instr_count` ← 0, `timeout` ← 0, next state LOAD.
- LOAD:
  - Drives `pc_start`=1, `pc_start_addr`=`addr_q`.
  - Next state RUN unconditionally. `go` is ignored.
- RUN: evaluated each cycle in strict priority order.
  1. `halt`: `pc_start`=1, `pc_start_addr`=`pc_in` (hold). Next state DONE. Not counted.
  2. `stall`: `pc_start`=1, `pc_start_addr`=`pc_in` (hold). Not counted. Stay in RUN.
  3. Otherwise the instruction retires:
     - `pc_branch`=`br_in`, `pc_taken`=`br_in & taken_in`, `pc_start`=0.
     - `instr_count` ← `instr_count`+1.
     - If `instr_count` == `MAX_INSTR`-1, set `timeout` ← 1 and next state DONE.
- DONE:
  - Drives `pc_start`=1, `pc_start_addr`=`pc_in`, holding the PC frozen.
  - `instr_count` and `timeout` hold their values.
  - On `go`: same capture as in IDLE, next state LOAD.
- `pc_branch` and `pc_taken` are 0 whenever `pc_start`=1.
- `taken_in` without `br_in` is ignored.
- `go` in RUN or LOAD is ignored; there is no abort other than reset.
- `instr_count` never wraps: the watchdog stops the run at `MAX_INSTR`.

## Timing
- Reset values: state IDLE, `addr_q`=0, `instr_count`=0, `timeout`=0.
- Output values while in reset: `pc_start`=1, `pc_start_addr`=0, `pc_branch`=0, `pc_taken`=0, `busy`=0, `done`=0.
- `rst_n` low at any time forces IDLE asynchronously. On the first edge after release, the PC loads 0.
- Go-to-execute latency: `go` accepted at edge E → LOAD during cycle E..E+1 → PC = `start_addr` after edge E+1. RUN begins at cycle E+1 with `pc_in` = `start_addr`.
- Retire timing: one instruction per RUN cycle without stall. `instr_count` is updated at the same edge that advances the PC.
- Halt: DONE is visible the cycle after `halt` is sampled. The PC stays on the HALT address.
- `halt` and `stall` together: halt wins.
- Watchdog terminal cycle: that instruction retires (count reaches `MAX_INSTR`). `timeout`=1 and `done`=1 are visible from the next cycle.
- `go` in DONE: restart with identical latency. `instr_count` clears at the accepting edge.

## Test plan
- Reset, then `go` with `start_addr`=0x010; no branches, no stall → `pc_in` reads 0x010, 0x011, 0x012… from RUN entry. `busy`=1. `instr_count` increments each cycle.
- In RUN with `br_in`=1, `taken_in`=0 → `pc_branch`=1, `pc_taken`=0, PC +2. With `br_in`=1, `taken_in`=1 → `pc_taken`=1, and the PC applies its signed target (e.g. -3). Count +1 in each case.
- `stall` held 3 cycles at PC 0x015 → `pc_start`=1, `pc_start_addr`=0x015, PC stays 0x015, `instr_count` unchanged. Execution resumes at 0x015.
- `halt` and `stall` asserted together at PC 0x020 after 16 retired → `done`=1 next cycle, PC stays 0x020, `instr_count`=16, `timeout`=0. `go` then restarts from the new `start_addr` and clears the count.
- `MAX_INSTR`=8, never halt → `done`=1 and `timeout`=1 after 8 retired, `instr_count`=8. A `go` pulse during RUN has no effect.
- Drop `rst_n` mid-RUN (count=5) → outputs go immediately to IDLE values, `instr_count`=0. PC = 0 after the next edge.
